pll_lock_reset_seq: RTL and testbench
=====================================

# pll_lock_reset_seq

Sequences system reset from the rPLL lock indication and generates the TRS-80 Model III CPU clock-enable in the PLL output clock domain. Sits directly downstream of the Gowin rPLL. It consumes the PLL output as its clock and the asynchronous `LOCK` as data. It feeds `sys_rst_n` and `cpu_ce` to all core logic. Lock loss at any time forces the design back into reset.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: lock must be continuously high for this many cycles before reset hold begins; ≥1.
- `RST_HOLD_CYCLES`, 16: cycles `sys_rst_n` stays low after the stable-lock window; ≥1.
- `ACC_WIDTH`, 24: phase-accumulator width.
- `PHASE_INC`, 272402: accumulator increment; 2.02752 MHz from 124.875 MHz; 0 < PHASE_INC < 2^ACC_WIDTH.
- `clk` in 1: PLL output clock, 124.875 MHz.
- `rst_n` in 1: asynchronous, active-low board reset.
- `pll_lock` in 1: rPLL LOCK, asynchronous to `clk`.
- `clr_cnt` in 1: synchronous clear of `lock_lost_cnt`.
- `sys_rst_n` out 1: registered system reset, active-low.
- `ready` out 1: high only in RUN.
- `cpu_ce` out 1: single-cycle CPU clock-enable pulse.
- `lock_lost_cnt` out 8: saturating count of lock-loss events.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. Only `lock_s` is used.
- States:
  - WAIT_LOCK (reset state)
  - STABLE
  - HOLD
  - RUN
- One counter `cnt`, wide enough for max(L,H). L=LOCK_STABLE_CYCLES, H=RST_HOLD_CYCLES.
- WAIT_LOCK: `cnt`=0. If `lock_s`=1, go to STABLE.
- STABLE: `cnt` increments each cycle. Go to HOLD with `cnt`=0 when `cnt`=L-1.
- HOLD: `cnt` increments each cycle. Go to RUN when `cnt`=H-1.
- RUN: stays in RUN while `lock_s`=1.
- Lock loss: `lock_s`=0 in STABLE, HOLD or RUN goes to WAIT_LOCK next edge with `cnt`=0. This takes priority over any counter-terminal transition in the same cycle.
- Registered Moore outputs:
  - `sys_rst_n`=1 and `ready`=1 exactly when the next state is RUN.
  - Both drop in the same edge that leaves RUN.
- Phase accumulator `acc` (ACC_WIDTH bits):
  - In RUN: `acc`<=`acc`+PHASE_INC modulo 2^ACC_WIDTH, and `cpu_ce`<=carry-out of that add.
  - Outside RUN: `acc`=0 and `cpu_ce`=0.
  - Average `cpu_ce` rate is f_clk·PHASE_INC/2^ACC_WIDTH. Consecutive pulse spacing differs by at most one cycle.
- Async reset (`rst_n`=0):
  - Synchronizer cleared, state WAIT_LOCK, `cnt`=0, `acc`=0.
  - `sys_rst_n`=0, `ready`=0, `cpu_ce`=0, `lock_lost_cnt`=0.
  - Applies immediately, mid-sequence included.

## Timing
- Edge numbering: edge 1 is the first edge sampling `pll_lock`=1.
  - `lock_s`=1 after edge 2.
  - STABLE entered at edge 3.
  - HOLD entered at edge 3+L.
  - RUN entered at edge 3+L+H; `sys_rst_n` and `ready` rise at that edge.
- Lock-loss latency: `pll_lock` falls, and `sys_rst_n` falls at the 3rd following edge (2 sync + 1 register).
- `cpu_ce` first pulse: edge k after RUN entry, where k = ceil(2^ACC_WIDTH/PHASE_INC). Never asserted in the RUN-entry cycle itself.
- Glitch on `pll_lock` shorter than one clock period may be missed. Any lock_s low sample restarts the sequence.

## Configuration
- `LOCK_LOSS_COUNT_EN` defined:
  - `lock_lost_cnt` increments by 1 on every STABLE/HOLD/RUN→WAIT_LOCK transition caused by `lock_s`=0. It saturates at 255.
  - `clr_cnt` clears it to 0.
  - Simultaneous `clr_cnt` and loss event gives 1.
- Not defined: `lock_lost_cnt` is constant 0, `clr_cnt` is ignored, and no counter logic is synthesized.

## Test plan
All scenarios use L=4, H=2 unless stated.
1. Basic sequence, ACC_WIDTH=4, PHASE_INC=4: `pll_lock` held 1 from edge 1.
   - `sys_rst_n`/`ready` rise at edge 9.
   - `cpu_ce` pulses at RUN edges 4, 8, 12 (every 4 cycles, 1 cycle wide).
2. Lock glitch in STABLE: `pll_lock`=0 for 2 cycles after edge 5, then 1.
   - Returns to WAIT_LOCK.
   - `sys_rst_n` stays 0.
   - Full L+H sequence restarts from the new rise.
   - `lock_lost_cnt`=1.
3. Lock loss in RUN: `pll_lock` falls.
   - `sys_rst_n`, `ready` and `cpu_ce` are 0 at the 3rd following edge.
   - `acc` is 0.
   - `lock_lost_cnt` increments.
4. Async reset mid-HOLD: `rst_n` low for half a cycle.
   - All outputs 0 immediately, with no clock edge needed.
   - After release with `pll_lock`=1, RUN is entered at edge 9 again.
5. Counter saturation and clear, with `LOCK_LOSS_COUNT_EN`:
   - 260 loss events give `lock_lost_cnt`=255.
   - `clr_cnt` coinciding with a loss event gives 1.
   - Rebuilt without the macro, `lock_lost_cnt`=0 throughout.
6. Rate check, defaults: over 124875 RUN cycles, `cpu_ce` count is 2027 or 2028.

Source files
------------

// File: rtl/pll_lock_reset_seq.sv
// Releases system reset once the rPLL lock has been stable for a while, and
// derives the CPU clock-enable from a phase accumulator. LOCK_LOSS_COUNT_EN adds a lock-loss event counter.
//
// state     | meaning
// WAIT_LOCK | waiting for synchronized lock, cnt held at 0
// STABLE    | lock must stay high for LOCK_STABLE_CYCLES
// HOLD      | sys_rst_n kept low for RST_HOLD_CYCLES more
// RUN       | reset released, cpu_ce running
module pll_lock_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int ACC_WIDTH          = 24,
    parameter int PHASE_INC          = 272402
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       clr_cnt,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       cpu_ce,
    output logic [7:0] lock_lost_cnt
);

    localparam int MAX_LH = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                            LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W  = (MAX_LH > 1) ? $clog2(MAX_LH) : 1;

    localparam logic [CNT_W-1:0]     STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [ACC_WIDTH-1:0] INC         = ACC_WIDTH'(PHASE_INC);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic               lock_s;
    logic               lock_loss;
    logic               run_q;
    logic               run_stay;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH:0]   acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lock_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock loss is checked before the terminal count so it always wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lock_loss = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    lock_loss = 1'b1;
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    lock_loss = 1'b1;
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    lock_loss = 1'b1;
                    state_d   = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= (state_d == RUN);
        end
    end

    assign sys_rst_n = run_q;
    assign ready     = run_q;

    // Accumulate only between RUN cycles, so the entry edge never pulses
    // and the exit edge clears acc together with sys_rst_n.
    assign run_stay = (state_q == RUN) && (state_d == RUN);
    assign acc_sum  = {1'b0, acc_q} + {1'b0, INC};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cpu_ce <= 1'b0;
        end else if (run_stay) begin
            acc_q  <= acc_sum[ACC_WIDTH-1:0];
            cpu_ce <= acc_sum[ACC_WIDTH];
        end else begin
            acc_q  <= '0;
            cpu_ce <= 1'b0;
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q <= 8'd0;
        end else if (clr_cnt) begin
            lost_q <= lock_loss ? 8'd1 : 8'd0;
        end else if (lock_loss && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
        end
    end

    assign lock_lost_cnt = lost_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = clr_cnt | lock_loss;
    assign lock_lost_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios plus random lock patterns
// checked against a lock-run-length model; a second instance checks cpu_ce rate.
`timescale 1ns/1ps
module tb_pll_lock_reset_seq;

    localparam int L    = 4;
    localparam int H    = 2;
    localparam int W    = 4;
    localparam int INC  = 4;
    localparam int RW   = 24;
    localparam int RINC = 272402;

    logic       clk = 1'b0;
    logic       rst_n, pll_lock, clr_cnt, rate_lock;
    logic       sys_rst_n, ready, cpu_ce;
    logic [7:0] lock_lost_cnt;
    logic       r_sys_rst_n, r_ready, r_cpu_ce;
    logic [7:0] r_cnt;

    int vectors = 0;
    int miscompares = 0;

    bit sh1, sh2;
    int run;
    int m_cnt;

`ifdef LOCK_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H), .ACC_WIDTH(W), .PHASE_INC(INC)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .clr_cnt(clr_cnt),
        .sys_rst_n(sys_rst_n), .ready(ready), .cpu_ce(cpu_ce),
        .lock_lost_cnt(lock_lost_cnt)
    );

    pll_lock_reset_seq #(
        .LOCK_STABLE_CYCLES(L), .RST_HOLD_CYCLES(H), .ACC_WIDTH(RW), .PHASE_INC(RINC)
    ) u_rate (
        .clk(clk), .rst_n(rst_n), .pll_lock(rate_lock), .clr_cnt(1'b0),
        .sys_rst_n(r_sys_rst_n), .ready(r_ready), .cpu_ce(r_cpu_ce),
        .lock_lost_cnt(r_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sh1 = 1'b0;
        sh2 = 1'b0;
        run = 0;
        m_cnt = 0;
    endtask

    // Reference: RUN is reached once the synchronized lock has been high for
    // 1+L+H consecutive edges; cpu_ce fires when j*INC crosses a 2^W multiple.
    task automatic step();
        bit ls, loss, m_rdy, m_ce;
        int j;
        @(posedge clk);
        ls   = sh2;
        sh2  = sh1;
        sh1  = pll_lock;
        loss = !ls && (run > 0);
        run  = ls ? run + 1 : 0;
        if (CNT_EN) begin
            if (clr_cnt) m_cnt = loss ? 1 : 0;
            else if (loss && m_cnt < 255) m_cnt++;
        end
        m_rdy = (run >= 1 + L + H);
        j     = run - (1 + L + H);
        m_ce  = (j >= 1) &&
                (((longint'(j) * INC) >> W) != ((longint'(j - 1) * INC) >> W));
        @(negedge clk);
        chk("sys_rst_n", 32'(sys_rst_n), 32'(m_rdy));
        chk("ready", 32'(ready), 32'(m_rdy));
        chk("cpu_ce", 32'(cpu_ce), 32'(m_ce));
        chk("lock_lost_cnt", 32'(lock_lost_cnt), 32'(m_cnt));
    endtask

    // Called just after a falling edge; reset pulse ends before the next rise.
    task automatic areset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_cpu_ce"}, 32'(cpu_ce), 32'd0);
        chk({tag, "_cnt"}, 32'(lock_lost_cnt), 32'd0);
        #2 rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int last, cnt_ce, first, sp, lo;
        bit found, c;
        rst_n = 1'b0; pll_lock = 1'b0; clr_cnt = 1'b0; rate_lock = 1'b0;
        model_clear();
        #1;
        chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_cnt", 32'(lock_lost_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic sequence: RUN at edge 9, cpu_ce at RUN edges 4, 8, 12
        pll_lock = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            chk("t1_ready", 32'(ready), 32'(i >= 9));
            chk("t1_cpu_ce", 32'(cpu_ce), 32'(i >= 13 && ((i - 9) % 4) == 0));
        end

        // lock glitch early in the sequence
        areset("t2_rst");
        pll_lock = 1'b1;
        for (int i = 1; i <= 5; i++) step();
        pll_lock = 1'b0;
        step(); step();
        pll_lock = 1'b1;
        for (int i = 8; i <= 22; i++) begin
            step();
            chk("t2_ready", 32'(ready), 32'(i >= 16));
        end
        chk("t2_cnt", 32'(lock_lost_cnt), CNT_EN ? 32'd1 : 32'd0);

        // lock loss in RUN
        for (int i = 0; i < 3; i++) step();
        pll_lock = 1'b0;
        step(); step();
        chk("t3_ready_still", 32'(ready), 32'd1);
        step();
        chk("t3_sys_rst_n", 32'(sys_rst_n), 32'd0);
        chk("t3_ready", 32'(ready), 32'd0);
        chk("t3_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("t3_acc", 32'(u_dut.acc_q), 32'd0);
        chk("t3_cnt", 32'(lock_lost_cnt), CNT_EN ? 32'd2 : 32'd0);

        // async reset in RUN, then mid-HOLD, then restart
        pll_lock = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("t4_in_run", 32'(ready), 32'd1);
        areset("t4_run");
        for (int i = 1; i <= 8; i++) step();
        areset("t4_hold");
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("t4_ready", 32'(ready), 32'(i >= 9));
        end

        // saturation and clear coinciding with a loss event
        areset("t5_rst");
        for (int e = 0; e < 260; e++) begin
            pll_lock = 1'b1; step();
            pll_lock = 1'b0; step();
        end
        step(); step();
        chk("t5_sat", 32'(lock_lost_cnt), CNT_EN ? 32'd255 : 32'd0);
        pll_lock = 1'b1; step();
        pll_lock = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            c = !sh2 && (run > 0);
            clr_cnt = c;
            step();
            if (c) begin
                found = 1'b1;
                chk("t5_clr_loss", 32'(lock_lost_cnt), CNT_EN ? 32'd1 : 32'd0);
            end
        end
        chk("t5_loss_seen", 32'(found), 32'd1);
        clr_cnt = 1'b0;

        // random lock patterns and clears
        areset("rnd_rst");
        for (int s = 0; s < 60; s++) begin
            int hi, lw;
            hi = $urandom_range(1, 40);
            lw = $urandom_range(1, 4);
            pll_lock = 1'b1;
            for (int i = 0; i < hi; i++) begin
                clr_cnt = ($urandom_range(0, 19) == 0);
                step();
            end
            pll_lock = 1'b0;
            for (int i = 0; i < lw; i++) begin
                clr_cnt = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        clr_cnt = 1'b0;

        // rate check on the default-increment instance
        rate_lock = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rate_ready", 32'(r_ready), 32'(i >= 9));
        end
        chk("rate_sys_rst_n", 32'(r_sys_rst_n), 32'd1);
        lo = (1 << RW) / RINC;
        last = 0; cnt_ce = 0; first = 0;
        for (int i = 1; i <= 20000; i++) begin
            @(posedge clk); @(negedge clk);
            if (r_cpu_ce === 1'b1) begin
                cnt_ce++;
                if (last == 0) first = i;
                else begin
                    sp = i - last;
                    chk("rate_spacing", 32'(sp == lo || sp == lo + 1), 32'd1);
                end
                last = i;
            end
        end
        chk("rate_first", 32'(first), 32'(((1 << RW) + RINC - 1) / RINC));
        chk("rate_count", 32'(cnt_ce), 32'((longint'(20000) * RINC) >> RW));
        chk("rate_lost_cnt", 32'(r_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
